// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmitter: FSM state encoding and the stereo
// frame word ({left, right}, left in the MSBs) at the default sample width.
package i2s_pkg;

  localparam int I2S_DWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  typedef logic [2*I2S_DWIDTH-1:0] frame_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit clock divider and bit position counter for the I2S transmitter.
// Produces a registered bclk plus bit-tick / frame-tick strobes.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4,
  localparam int BIT_W     = $clog2(2*SLOT_WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  output logic             bclk_o,
  output logic             bit_tick_o,
  output logic             frame_tick_o,
  output logic [BIT_W-1:0] next_bit_cnt_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(2*SLOT_WIDTH - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;

  // bclk is registered from the next divider value so it falls on the same
  // edge that ends a bit tick, which is when lrck/sdata change.
  always_comb begin
    bit_tick_o   = run_i && (div_cnt_q == DIV_MAX);
    frame_tick_o = bit_tick_o && (bit_cnt_q == BIT_MAX);
    div_cnt_d    = '0;
    bit_cnt_d    = '0;
    if (run_i) begin
      div_cnt_d = bit_tick_o ? '0 : div_cnt_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      if (bit_tick_o) begin
        bit_cnt_d = frame_tick_o ? '0 : bit_cnt_q + 1'b1;
      end
    end
    bclk_d = (div_cnt_d >= DIV_HALF);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o         = bclk_q;
  assign next_bit_cnt_o = bit_cnt_d;

endmodule

// File: rtl/i2s_tx.sv
// I2S (Philips) transmitter fed from a showahead FIFO, one {left,right} word per frame.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt_o counter.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DWIDTH     = I2S_DWIDTH,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [2*DWIDTH-1:0] fifo_data_i,
  input  logic                fifo_empty_i,
  output logic                fifo_rd_req_o,
  output logic                bclk_o,
  output logic                lrck_o,
  output logic                sdata_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_cnt_o
`endif
);

  localparam int FW    = 2*DWIDTH;
  localparam int IDX_W = $clog2(FW);
  localparam int BIT_W = $clog2(2*SLOT_WIDTH);

  state_t            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              lrck_q, lrck_d;
  logic              sdata_q, sdata_d;
  logic              stop_q, stop_d;
  logic              stopping;
  logic              bit_tick, frame_tick;
  logic [BIT_W-1:0]  next_bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              slot_bit;
  int                pos;

  i2s_clk_gen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .BCLK_DIV   (BCLK_DIV)
  ) u_clk_gen (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .run_i          (state_q != IDLE),
    .bclk_o         (bclk_o),
    .bit_tick_o     (bit_tick),
    .frame_tick_o   (frame_tick),
    .next_bit_cnt_o (next_bit_cnt)
  );

  // Outputs are computed for the bit position about to start, so the
  // one-bit Philips delay falls out of the position-to-bit mapping.
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    lrck_d        = lrck_q;
    sdata_d       = sdata_q;
    stop_d        = stop_q;
    fifo_rd_req_o = 1'b0;
    stopping      = stop_q | ~enable_i;
    pos           = int'(next_bit_cnt);
    bit_idx       = '0;
    slot_bit      = 1'b0;

    if (pos >= 1 && pos <= DWIDTH) begin
      bit_idx  = IDX_W'(FW - pos);
      slot_bit = frame_q[bit_idx];
    end else if (pos >= SLOT_WIDTH + 1 && pos <= SLOT_WIDTH + DWIDTH) begin
      bit_idx  = IDX_W'(DWIDTH + SLOT_WIDTH - pos);
      slot_bit = frame_q[bit_idx];
    end

    case (state_q)
      IDLE: begin
        stop_d  = 1'b0;
        lrck_d  = 1'b0;
        sdata_d = 1'b0;
        frame_d = '0;
        if (enable_i) begin
          state_d = SYNC;
        end
      end
      SYNC, RUN: begin
        stop_d = stopping;
        if (bit_tick) begin
          lrck_d  = (pos >= SLOT_WIDTH);
          sdata_d = (state_q == RUN) ? slot_bit : 1'b0;
        end
        // A stop request is honoured only at a frame boundary.
        if (frame_tick) begin
          if (stopping) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            lrck_d  = 1'b0;
            sdata_d = 1'b0;
            frame_d = '0;
          end else if (!fifo_empty_i) begin
            fifo_rd_req_o = 1'b1;
            frame_d       = fifo_data_i;
            state_d       = RUN;
          end else if (state_q == RUN) begin
            frame_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      frame_q <= '0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      lrck_q  <= lrck_d;
      sdata_q <= sdata_d;
      stop_q  <= stop_d;
    end
  end

  assign lrck_o  = lrck_q;
  assign sdata_o = sdata_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (state_q == RUN && frame_tick && fifo_empty_i && underrun_cnt_q != 16'hFFFF) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      underrun_cnt_q <= 16'd0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: a FIFO model feeds random words, a negedge
// monitor deserialises each frame and compares it with the expected word.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int DWIDTH     = 16;
  localparam int SLOT_WIDTH = 32;
  localparam int BCLK_DIV   = 4;
  localparam int FRAME_BITS = 2*SLOT_WIDTH;
  localparam int FRAME_CYC  = FRAME_BITS*BCLK_DIV;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  frame_t      fifo_data_i = '0;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_rd_req_o;
  logic        bclk_o;
  logic        lrck_o;
  logic        sdata_o;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
`endif

  i2s_tx #(
    .DWIDTH     (DWIDTH),
    .SLOT_WIDTH (SLOT_WIDTH),
    .BCLK_DIV   (BCLK_DIV)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .fifo_data_i    (fifo_data_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_req_o  (fifo_rd_req_o),
    .bclk_o         (bclk_o),
    .lrck_o         (lrck_o),
    .sdata_o        (sdata_o)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int     vectors = 0;
  int     miscompares = 0;
  frame_t fifo_q[$];
  frame_t wr_q[$];
  frame_t exp_q[$];
  int     cyc = 0;
  int     pop_cnt = 0;
  int     popped = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Expected serial frame for word w, from the Philips slot rules.
  function automatic void expFrame(input frame_t w, output logic [63:0] sd, output logic [63:0] lr);
    logic [15:0] left;
    logic [15:0] right;
    left  = w[31:16];
    right = w[15:0];
    sd = '0;
    lr = '0;
    for (int p = 0; p < FRAME_BITS; p++) begin
      lr[p] = (p >= SLOT_WIDTH);
      if (p >= 1 && p <= DWIDTH)
        sd[p] = 1'((left >> (DWIDTH - p)) & 16'd1);
      else if (p >= SLOT_WIDTH + 1 && p <= SLOT_WIDTH + DWIDTH)
        sd[p] = 1'((right >> (SLOT_WIDTH + DWIDTH - p)) & 16'd1);
    end
  endfunction

  // FIFO model: applies pops seen by the monitor and queued writes, away from edges.
  always @(posedge clk_i) begin
    #1;
    if (rst_i) begin
      fifo_q.delete();
      wr_q.delete();
      popped = 0;
    end else begin
      while (popped < pop_cnt) begin
        if (fifo_q.size() > 0) fifo_q.delete(0);
        popped++;
      end
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    end
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  end

  logic [63:0] sd_vec, lr_vec, exp_sd, exp_lr;
  int          bit_m = 0;
  int          lat = -1;
  int          last_pop = 0;
  bit          capturing = 0, is_data = 0, prev_data = 0, prev_bclk = 0, lat_msb = 0;
  frame_t      word;

  // Monitor: samples on the falling clk edge, collects one bit per bclk rise.
  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      capturing = 0;
      is_data   = 0;
      prev_data = 0;
      bit_m     = 0;
      pop_cnt   = 0;
      lat       = -1;
      prev_bclk = 0;
      exp_q.delete();
    end else begin
      if (lat >= 0) begin
        lat++;
        if (lat == BCLK_DIV) checkOutput("latency_pos0", sdata_o, 0);
        else if (lat == BCLK_DIV + 1) begin
          checkOutput("latency_msb", sdata_o, lat_msb);
          lat = -1;
        end
      end
      if (capturing && bclk_o && !prev_bclk) begin
        sd_vec[bit_m] = sdata_o;
        lr_vec[bit_m] = lrck_o;
        bit_m++;
        if (bit_m == FRAME_BITS) begin
          word = '0;
          if (is_data) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("[TB] FAIL scoreboard_underflow: actual=frame required=no frame");
            end else word = exp_q.pop_front();
          end
          expFrame(word, exp_sd, exp_lr);
          checkOutput(is_data ? "data_frame_sdata" : "zero_frame_sdata", sd_vec, exp_sd);
          checkOutput("frame_lrck", lr_vec, exp_lr);
          prev_data = is_data;
          is_data   = 0;
          bit_m     = 0;
        end
      end
      if (fifo_rd_req_o) begin
        checkOutput("pop_while_empty", fifo_empty_i, 0);
        if (capturing) begin
          checkOutput("pop_alignment", 64'(bit_m), 0);
          if (prev_data) checkOutput("pop_spacing", 64'(cyc - last_pop), FRAME_CYC);
        end
        lat_msb   = (exp_q.size() > 0) ? exp_q[0][31] : 1'b0;
        lat       = 0;
        last_pop  = cyc;
        capturing = 1;
        is_data   = 1;
        bit_m     = 0;
        pop_cnt++;
      end
      prev_bclk = bclk_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    rst_i    = rst;
    enable_i = en;
  endtask

  task automatic pushWord(input frame_t w);
    wr_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic checkIdle(input string name);
    checkOutput(name, {bclk_o, lrck_o, sdata_o, fifo_rd_req_o}, 0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0);
    tick(3);
    checkIdle("reset_outputs");
    applyStimulus(1'b0, 1'b0);
    tick(1);
  endtask

  task automatic waitPops(input int target, input int budget, input string name);
    int k = 0;
    while (pop_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput(name, 64'(pop_cnt), 64'(target));
  endtask

  // Waits on the falling edge until a pop is seen; returns on that falling edge.
  task automatic waitPopEdge(input string name);
    int k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!fifo_rd_req_o && k < 2*FRAME_CYC);
    checkOutput(name, fifo_rd_req_o, 1);
  endtask

  initial begin
    logic [15:0] bv;
    bit          ok;
    bit          any_sd;

    $display("[TB] i2s_tx scoreboard bench start");
    applyStimulus(1'b1, 1'b0);
    tick(3);
    checkIdle("reset_outputs");
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checkOutput("reset_underrun", underrun_cnt_o, 0);
`endif

    // Stays idle after reset while enable is low, even with data waiting.
    applyStimulus(1'b0, 1'b0);
    tick(1);
    pushWord($urandom);
    tick(300);
    checkIdle("idle_hold");
    checkOutput("idle_no_pop", 64'(pop_cnt), 0);
    doReset();

    // SYNC with an empty FIFO, then the reference word.
    applyStimulus(1'b0, 1'b1);
    tick(10);
    for (int i = 0; i < 16; i++) begin
      bv[i] = bclk_o;
      tick(1);
    end
    ok = 1;
    for (int i = 0; i < 12; i++) begin
      if (bv[i] != bv[i+4] || bv[i] == bv[i+2]) ok = 0;
    end
    checkOutput("sync_bclk_period", ok, 1);
    any_sd = 0;
    for (int i = 0; i < 600; i++) begin
      if (sdata_o !== 1'b0) any_sd = 1;
      tick(1);
    end
    checkOutput("sync_sdata_zero", any_sd, 0);
    checkOutput("sync_no_pops", 64'(pop_cnt), 0);
    pushWord(32'hA5A5_0F0F);
    waitPops(1, FRAME_CYC + 50, "sync_to_run_pop");
    tick(FRAME_CYC + 50);
    doReset();

    // Back-to-back random frames.
    for (int i = 0; i < 100; i++) pushWord($urandom);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    waitPops(100, 100*FRAME_CYC + 600, "b2b_pops_reached");
    applyStimulus(1'b0, 1'b0);
    tick(FRAME_CYC + 50);
    checkOutput("b2b_pop_total", 64'(pop_cnt), 100);
    checkIdle("b2b_idle_after_stop");
    doReset();

    // Enable dropped at bit position 10.
    pushWord($urandom);
    pushWord($urandom);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    waitPopEdge("stop_first_pop");
    repeat (41) @(posedge clk_i);
    #2;
    applyStimulus(1'b0, 1'b0);
    repeat (214) @(posedge clk_i);
    #2;
    checkOutput("stop_last_bit_running", {bclk_o, lrck_o}, 2'b11);
    repeat (2) @(posedge clk_i);
    #2;
    checkIdle("stop_idle_after_frame");
    tick(40);
    checkIdle("stop_idle_hold");
    checkOutput("stop_no_more_pops", 64'(pop_cnt), 1);
    doReset();

    // One underrun frame in RUN.
    pushWord($urandom);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    waitPops(1, 2*FRAME_CYC, "underrun_first_pop");
    tick(300);
    checkOutput("underrun_no_pop", 64'(pop_cnt), 1);
    pushWord($urandom);
    waitPops(2, 400, "underrun_second_pop");
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checkOutput("underrun_count", underrun_cnt_o, 1);
`endif
    tick(FRAME_CYC + 50);
    doReset();

    // Reset in the middle of bit position 20.
    pushWord($urandom);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    waitPopEdge("midreset_pop");
    repeat (83) @(posedge clk_i);
    #2;
    checkOutput("midreset_bclk_before", bclk_o, 1);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkIdle("midreset_async");
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checkOutput("midreset_underrun", underrun_cnt_o, 0);
`endif
    tick(3);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    pushWord($urandom);
    tick(300);
    checkIdle("midreset_idle_after");
    checkOutput("midreset_no_pop", 64'(pop_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
